// File: rtl/vga_timing_gen_p.sv
// VGA timing generator: counts pixel ticks, issues frame-buffer requests ahead of display,
// and re-times the returned colour with sync/de so outputs lag req_* by PIX_LATENCY+1 ce ticks.
module vga_timing_gen_p #(
  parameter int CW          = 11,
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int H_POL       = 1,
  parameter int V_POL       = 1,
  parameter int R_W         = 4,
  parameter int G_W         = 4,
  parameter int B_W         = 4,
  parameter int PIX_LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [R_W+G_W+B_W-1:0]   Pix_color,
  output logic                     req_valid,
  output logic [CW-1:0]            req_x,
  output logic [CW-1:0]            req_y,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     de,
  output logic [R_W-1:0]           Red,
  output logic [G_W-1:0]           Green,
  output logic [B_W-1:0]           Blue,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int PIX_W   = R_W + G_W + B_W;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic          HS_ON  = 1'(H_POL);
  localparam logic          VS_ON  = 1'(V_POL);

  if (PIX_LATENCY < 0 || PIX_LATENCY > 8) begin : g_bad_latency
    $error("vga_timing_gen_p: PIX_LATENCY must be within 0..8");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen_p: porch and sync widths must be non-zero");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
    $error("vga_timing_gen_p: H_TOTAL/V_TOTAL exceed counter range");
  end

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } flags_t;

  logic [CW-1:0]    hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0]    req_x_q, req_x_d, req_y_q, req_y_d;
  // Stage 0 sits beside the request registers; stage PIX_LATENCY feeds the outputs.
  flags_t           stg_q [0:PIX_LATENCY];
  flags_t           stg_d [0:PIX_LATENCY];
  flags_t           cur, last;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [PIX_W-1:0] color_q, color_d;
  logic             ls_q, ls_d, fs_q, fs_d;

  always_comb begin
    cur.act = (hc_q < H_ACT) && (vc_q < V_ACT);
    cur.hs  = (hc_q >= HS_BEG) && (hc_q < HS_END);
    cur.vs  = (vc_q >= VS_BEG) && (vc_q < VS_END);
    cur.ls  = cur.act && (hc_q == '0);
    cur.fs  = cur.act && (hc_q == '0) && (vc_q == '0);
    last    = stg_q[PIX_LATENCY];

    hc_d    = hc_q;
    vc_d    = vc_q;
    req_x_d = req_x_q;
    req_y_d = req_y_q;
    stg_d   = stg_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    color_d = color_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    if (ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
      req_x_d  = hc_q;
      req_y_d  = vc_q;
      stg_d[0] = cur;
      for (int i = 1; i <= PIX_LATENCY; i++) begin
        stg_d[i] = stg_q[i-1];
      end
      hsync_d = last.hs ? HS_ON : ~HS_ON;
      vsync_d = last.vs ? VS_ON : ~VS_ON;
      de_d    = last.act;
      color_d = last.act ? Pix_color : '0;
      // Pulses are only loaded on a tick so they clear on the next clk when ce is throttled.
      ls_d    = last.ls;
      fs_d    = last.fs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      req_x_q <= '0;
      req_y_q <= '0;
      for (int i = 0; i <= PIX_LATENCY; i++) begin
        stg_q[i] <= '0;
      end
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      color_q <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
      stg_q   <= stg_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      color_q <= color_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign req_valid   = stg_q[0].act;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign de          = de_q;
  assign Red         = color_q[R_W-1:0];
  assign Green       = color_q[R_W+G_W-1:R_W];
  assign Blue        = color_q[PIX_W-1:R_W+G_W];
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Bench for vga_timing_gen_p: three instances (small timing at latency 0 and 3, default timing
// with inverted polarity) checked every clk against a queued reference model plus directed sequences.
module tb_vga_timing_gen_p;

  typedef struct packed {
    int   ha, hf, hs, hb, va, vf, vs, vb;
    logic hp, vp;
  } tim_t;

  typedef struct packed {
    logic        rv;
    logic [15:0] x;
    logic [15:0] y;
    logic        hs, vs, de;
    logic [11:0] col;
    logic        ls, fs;
  } exp_t;

  typedef struct packed {
    logic       white;
    logic [2:0] hc;
    logic       de, hs;
    logic [3:0] red;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic ce_a, ce_b, ce_c;
  logic white, throttle, run;
  int   div;
  tim_t ta, tbt, tc;

  logic [11:0] pix_a, pix_b, pix_c;
  logic [11:0] pb [0:2];

  logic       req_valid_a, Hsync_a, Vsync_a, de_a, line_start_a, frame_start_a;
  logic [5:0] req_x_a, req_y_a;
  logic [3:0] Red_a, Green_a, Blue_a;
  logic       req_valid_b, Hsync_b, Vsync_b, de_b, line_start_b, frame_start_b;
  logic [7:0] req_x_b, req_y_b;
  logic [3:0] Red_b, Green_b, Blue_b;
  logic        req_valid_c, Hsync_c, Vsync_c, de_c, line_start_c, frame_start_c;
  logic [10:0] req_x_c, req_y_c;
  logic [3:0]  Red_c, Green_c, Blue_c;

  vga_timing_gen_p #(.CW(6), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIX_LATENCY(0)) u_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .Pix_color(pix_a), .req_valid(req_valid_a),
    .req_x(req_x_a), .req_y(req_y_a), .Hsync(Hsync_a), .Vsync(Vsync_a), .de(de_a),
    .Red(Red_a), .Green(Green_a), .Blue(Blue_a), .line_start(line_start_a), .frame_start(frame_start_a));

  vga_timing_gen_p #(.CW(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIX_LATENCY(3)) u_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .Pix_color(pix_b), .req_valid(req_valid_b),
    .req_x(req_x_b), .req_y(req_y_b), .Hsync(Hsync_b), .Vsync(Vsync_b), .de(de_b),
    .Red(Red_b), .Green(Green_b), .Blue(Blue_b), .line_start(line_start_b), .frame_start(frame_start_b));

  vga_timing_gen_p #(.H_POL(0), .V_POL(0)) u_c (
    .clk(clk), .rst(rst_c), .ce(ce_c), .Pix_color(pix_c), .req_valid(req_valid_c),
    .req_x(req_x_c), .req_y(req_y_c), .Hsync(Hsync_c), .Vsync(Vsync_c), .de(de_c),
    .Red(Red_c), .Green(Green_c), .Blue(Blue_c), .line_start(line_start_c), .frame_start(frame_start_c));

  // Frame-buffer stand-ins: combinational for latency 0, a 3-tick ce-gated pipe for u_b.
  assign pix_a = white ? 12'hFFF : {req_y_a[3:0], 2'b00, req_x_a};
  assign pix_c = {req_y_c[3:0], req_x_c[7:0]};
  assign pix_b = pb[2];

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pb[0] <= '0; pb[1] <= '0; pb[2] <= '0;
    end else if (ce_b) begin
      pb[0] <= {req_y_b[3:0], req_x_b};
      pb[1] <= pb[0];
      pb[2] <= pb[1];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic tim_t mk_tim(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                                  logic hp, logic vp);
    tim_t t;
    t.ha = ha; t.hf = hf; t.hs = hs; t.hb = hb;
    t.va = va; t.vf = vf; t.vs = vs; t.vb = vb;
    t.hp = hp; t.vp = vp;
    return t;
  endfunction

  function automatic logic [11:0] pixf(int x, int y, logic w);
    logic [15:0] xx, yy;
    xx = 16'(x);
    yy = 16'(y);
    return w ? 12'hFFF : {yy[3:0], xx[7:0]};
  endfunction

  function automatic exp_t rst_exp(tim_t t);
    exp_t e;
    e = '0;
    e.hs = ~t.hp;
    e.vs = ~t.vp;
    return e;
  endfunction

  function automatic exp_t model(tim_t t, int hc, int vc, logic w);
    exp_t e;
    logic a;
    a     = (hc < t.ha) && (vc < t.va);
    e.rv  = a;
    e.x   = 16'(hc);
    e.y   = 16'(vc);
    e.de  = a;
    e.hs  = ((hc >= t.ha + t.hf) && (hc < t.ha + t.hf + t.hs)) ? t.hp : ~t.hp;
    e.vs  = ((vc >= t.va + t.vf) && (vc < t.va + t.vf + t.vs)) ? t.vp : ~t.vp;
    e.col = a ? pixf(hc, vc, w) : 12'h000;
    e.ls  = a && (hc == 0);
    e.fs  = a && (hc == 0) && (vc == 0);
    return e;
  endfunction

  task automatic adv(input tim_t t, inout int h, inout int v);
    if (h == t.ha + t.hf + t.hs + t.hb - 1) begin
      h = 0;
      v = (v == t.va + t.vf + t.vs + t.vb - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  function automatic exp_t mk(logic rv, logic [15:0] x, logic [15:0] y, logic hs, logic vs, logic d,
                              logic [11:0] col, logic ls, logic fs);
    exp_t e;
    e.rv = rv; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.de = d; e.col = col; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  function automatic logic [63:0] rq(exp_t e);
    return 64'({e.rv, e.x, e.y});
  endfunction

  function automatic logic [63:0] oq(exp_t e);
    return 64'({e.hs, e.vs, e.de, e.col, e.ls, e.fs});
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Scoreboard: each ce tick pushes the expected display record of the current request; the
  // record leaves the queue when the DUT loads its outputs, PIX_LATENCY+1 ticks later.
  exp_t qa[$], qb[$], qc[$];
  exp_t ra, oa, rb, ob, rc, oc;
  int   ha, va, hb, vb, hcc, vcc;

  initial forever begin
    @(posedge clk or posedge rst_a);
    if (rst_a) begin
      qa.delete(); ha = 0; va = 0; ra = rst_exp(ta); oa = ra;
    end else if (ce_a) begin
      ra = model(ta, ha, va, white);
      qa.push_back(ra);
      if (qa.size() > 1) oa = qa.pop_front();
      adv(ta, ha, va);
    end else begin
      oa.ls = 1'b0; oa.fs = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk or posedge rst_b);
    if (rst_b) begin
      qb.delete(); hb = 0; vb = 0; rb = rst_exp(tbt); ob = rb;
    end else if (ce_b) begin
      rb = model(tbt, hb, vb, 1'b0);
      qb.push_back(rb);
      if (qb.size() > 4) ob = qb.pop_front();
      adv(tbt, hb, vb);
    end else begin
      ob.ls = 1'b0; ob.fs = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk or posedge rst_c);
    if (rst_c) begin
      qc.delete(); hcc = 0; vcc = 0; rc = rst_exp(tc); oc = rc;
    end else if (ce_c) begin
      rc = model(tc, hcc, vcc, 1'b0);
      qc.push_back(rc);
      if (qc.size() > 1) oc = qc.pop_front();
      adv(tc, hcc, vcc);
    end else begin
      oc.ls = 1'b0; oc.fs = 1'b0;
    end
  end

  initial forever begin
    exp_t g;
    @(negedge clk);
    if (run) begin
      g = mk(req_valid_a, 16'(req_x_a), 16'(req_y_a), Hsync_a, Vsync_a, de_a,
             {Blue_a, Green_a, Red_a}, line_start_a, frame_start_a);
      chk("a_req", rq(g), rq(ra));
      chk("a_out", oq(g), oq(oa));
      g = mk(req_valid_b, 16'(req_x_b), 16'(req_y_b), Hsync_b, Vsync_b, de_b,
             {Blue_b, Green_b, Red_b}, line_start_b, frame_start_b);
      chk("b_req", rq(g), rq(rb));
      chk("b_out", oq(g), oq(ob));
      g = mk(req_valid_c, 16'(req_x_c), 16'(req_y_c), Hsync_c, Vsync_c, de_c,
             {Blue_c, Green_c, Red_c}, line_start_c, frame_start_c);
      chk("c_req", rq(g), rq(rc));
      chk("c_out", oq(g), oq(oc));
    end
  end

  // ce for u_b: every clk, or one clk in three while throttled.
  initial begin
    ce_b = 1'b1;
    div  = 0;
    forever begin
      @(negedge clk);
      if (throttle) begin
        div  = (div == 2) ? 0 : div + 1;
        ce_b = (div == 0);
      end else begin
        div  = 0;
        ce_b = 1'b1;
      end
    end
  end

  task automatic reset_a(input logic w);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    white = w;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  vec_t tbl [16];

  initial begin
    int found, per, vsn, vs0, den, lsn, fsn, lown, low0, vlow;

    tbl[0]  = '{1'b0, 3'd0, 1'b1, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 3'd1, 1'b1, 1'b0, 4'h1};
    tbl[2]  = '{1'b0, 3'd2, 1'b1, 1'b0, 4'h2};
    tbl[3]  = '{1'b0, 3'd3, 1'b1, 1'b0, 4'h3};
    tbl[4]  = '{1'b0, 3'd4, 1'b0, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 3'd5, 1'b0, 1'b1, 4'h0};
    tbl[6]  = '{1'b0, 3'd6, 1'b0, 1'b1, 4'h0};
    tbl[7]  = '{1'b0, 3'd7, 1'b0, 1'b0, 4'h0};
    tbl[8]  = '{1'b1, 3'd0, 1'b1, 1'b0, 4'hF};
    tbl[9]  = '{1'b1, 3'd1, 1'b1, 1'b0, 4'hF};
    tbl[10] = '{1'b1, 3'd2, 1'b1, 1'b0, 4'hF};
    tbl[11] = '{1'b1, 3'd3, 1'b1, 1'b0, 4'hF};
    tbl[12] = '{1'b1, 3'd4, 1'b0, 1'b0, 4'h0};
    tbl[13] = '{1'b1, 3'd5, 1'b0, 1'b1, 4'h0};
    tbl[14] = '{1'b1, 3'd6, 1'b0, 1'b1, 4'h0};
    tbl[15] = '{1'b1, 3'd7, 1'b0, 1'b0, 4'h0};

    ta  = mk_tim(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    tbt = mk_tim(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    tc  = mk_tim(800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ce_a = 1'b1; ce_c = 1'b1;
    white = 1'b0; throttle = 1'b0; run = 1'b0;

    repeat (2) @(negedge clk);
    run = 1'b1;
    chk("c_rst_hsync", Hsync_c, 1'b1);
    chk("c_rst_vsync", Vsync_c, 1'b1);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Asynchronous reset in the middle of a line while Hsync is active.
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      @(negedge clk);
      found = int'(Hsync_a);
    end
    chk("a_hs_before_rst", 64'(found), 64'd1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("a_rst_async", {Hsync_a, Vsync_a, de_a, Red_a, Green_a, Blue_a, req_x_a, req_y_a}, '0);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    chk("a_req_valid_first", {req_valid_a, req_x_a, req_y_a}, {1'b1, 12'h000});

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].hc == 3'd0) begin
        reset_a(tbl[i].white);
        @(posedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_de", i), de_a, tbl[i].de);
      chk($sformatf("tbl%0d_hs", i), Hsync_a, tbl[i].hs);
      chk($sformatf("tbl%0d_red", i), Red_a, tbl[i].red);
    end

    // One full small frame on u_a with white pixels.
    found = 0;
    for (int n = 0; n < 80 && found == 0; n++) begin
      @(negedge clk);
      found = int'(frame_start_a);
    end
    chk("a_fs_seen", 64'(found), 64'd1);
    per = -1; vsn = 0; vs0 = -1; den = int'(de_a);
    for (int n = 1; n <= 100 && per < 0; n++) begin
      @(negedge clk);
      if (frame_start_a) per = n;
      else begin
        if (Vsync_a) begin
          vsn++;
          if (vs0 < 0) vs0 = n;
        end
        den += int'(de_a);
      end
    end
    chk("a_frame_period", 64'(per), 64'd48);
    chk("a_vsync_ticks", 64'(vsn), 64'd8);
    chk("a_vsync_offset", 64'(vs0), 64'd32);
    chk("a_de_ticks", 64'(den), 64'd12);

    // Latency-3 instance: pixel (0,0) is black under the coordinate pattern.
    found = 0;
    for (int n = 0; n < 300 && found == 0; n++) begin
      @(negedge clk);
      found = int'(frame_start_b);
    end
    chk("b_fs_seen", 64'(found), 64'd1);
    chk("b_fs_black", {Red_b, Green_b, Blue_b}, 12'h000);
    chk("b_fs_de", de_b, 1'b1);

    throttle = 1'b1;
    found = 0;
    for (int n = 0; n < 600 && found == 0; n++) begin
      @(negedge clk);
      found = int'(frame_start_b);
    end
    chk("b_thr_fs_seen", 64'(found), 64'd1);
    per = -1; lsn = int'(line_start_b); fsn = 0; den = int'(de_b);
    for (int n = 1; n <= 300 && per < 0; n++) begin
      @(negedge clk);
      fsn += int'(frame_start_b);
      if (frame_start_b) per = n;
      else begin
        lsn += int'(line_start_b);
        den += int'(de_b);
      end
    end
    chk("b_thr_period", 64'(per), 64'd144);
    chk("b_thr_ls_clks", 64'(lsn), 64'd3);
    chk("b_thr_fs_clks", 64'(fsn), 64'd1);
    chk("b_thr_de_clks", 64'(den), 64'd36);
    throttle = 1'b0;

    // Default 800x600 timing with active-low syncs: one full line.
    found = 0;
    for (int n = 0; n < 1200 && found == 0; n++) begin
      @(negedge clk);
      found = int'(line_start_c);
    end
    chk("c_ls_seen", 64'(found), 64'd1);
    per = -1; lown = 0; low0 = -1; vlow = 0;
    for (int n = 1; n <= 1100 && per < 0; n++) begin
      @(negedge clk);
      if (line_start_c) per = n;
      else begin
        if (!Hsync_c) begin
          lown++;
          if (low0 < 0) low0 = n;
        end
        vlow += int'(!Vsync_c);
      end
    end
    chk("c_line_period", 64'(per), 64'd1056);
    chk("c_hsync_start", 64'(low0), 64'd840);
    chk("c_hsync_width", 64'(lown), 64'd128);
    chk("c_vsync_idle", 64'(vlow), 64'd0);

    @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
